// File: rtl/tpg_cfg_pkg.sv
// Shared constants, types and register-map helpers for the TPG configuration sequencer.
package tpg_cfg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFFS_W = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [OFFS_W-1:0] OFF_CONTROL   = 8'h00;
  localparam logic [OFFS_W-1:0] OFF_ACTIVE_H  = 8'h10;
  localparam logic [OFFS_W-1:0] OFF_ACTIVE_W  = 8'h18;
  localparam logic [OFFS_W-1:0] OFF_BG_ID     = 8'h20;
  localparam logic [OFFS_W-1:0] OFF_COLOR_FMT = 8'h40;

  localparam logic [DATA_W-1:0] CTRL_START_AUTORESTART = 32'h0000_0081;
  localparam logic [DATA_W-1:0] CTRL_STOP              = 32'h0000_0000;
  localparam int unsigned       AP_IDLE_BIT            = 2;
  localparam logic [IDX_W-1:0]  LAST_IDX               = 3'd4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [3:0] {
    IDLE,
    STOP_WR,
    STOP_B,
    POLL_AR,
    POLL_R,
    CFG_WR,
    CFG_B,
    RUN,
    ERR
  } seq_state_t;

  typedef struct packed {
    logic [15:0] height;
    logic [15:0] width;
    logic [7:0]  pattern;
    logic [7:0]  format;
  } tpg_cfg_t;

  // Register offset of configuration write number idx; the last one starts the core.
  function automatic logic [OFFS_W-1:0] cfg_offset(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    return OFF_ACTIVE_H;
      3'd1:    return OFF_ACTIVE_W;
      3'd2:    return OFF_BG_ID;
      3'd3:    return OFF_COLOR_FMT;
      default: return OFF_CONTROL;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] cfg_data(input logic [IDX_W-1:0] idx,
                                                 input tpg_cfg_t cfg);
    case (idx)
      3'd0:    return DATA_W'(cfg.height);
      3'd1:    return DATA_W'(cfg.width);
      3'd2:    return DATA_W'(cfg.pattern);
      3'd3:    return DATA_W'(cfg.format);
      default: return CTRL_START_AUTORESTART;
    endcase
  endfunction

endpackage

// File: rtl/axil_wr_channel.sv
// Single AXI4-Lite write: issues AW and W together, drops each after its own
// handshake, then collects the B response and reports it with a done pulse.
module axil_wr_channel
  import tpg_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              accepted,
  output logic              done,
  output axi_resp_t         resp
);

  logic aw_done;
  logic w_done;
  logic aw_hs;
  logic w_hs;

  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign accepted = bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awaddr  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      done    <= 1'b0;
      resp    <= OKAY;
    end else begin
      done <= 1'b0;
      if (start) begin
        awaddr  <= addr;
        wdata   <= data;
        wstrb   <= {STRB_W{1'b1}};
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) begin
          awvalid <= 1'b0;
          aw_done <= 1'b1;
        end
        if (w_hs) begin
          wvalid <= 1'b0;
          w_done <= 1'b1;
        end
        // Both channels accepted (in either order): open the response phase.
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          bready  <= 1'b1;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        if (bready && bvalid) begin
          bready <= 1'b0;
          done   <= 1'b1;
          resp   <= axi_resp_t'(bresp);
        end
      end
    end
  end

endmodule

// File: rtl/tpg_cfg_sequencer.sv
// AXI4-Lite master that programs and starts the video TPG in free-running mode,
// stopping it and waiting for ap_idle first when it is already running.
module tpg_cfg_sequencer
  import tpg_cfg_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       POLL_MAX  = 1024
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cfg_start,
  input  logic [15:0]       cfg_height,
  input  logic [15:0]       cfg_width,
  input  logic [7:0]        cfg_pattern,
  input  logic [7:0]        cfg_format,
  output logic              busy,
  output logic              running,
  output logic              error,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int unsigned      PC_W       = $clog2(POLL_MAX + 1);
  localparam logic [PC_W-1:0]  POLL_LIMIT = PC_W'(POLL_MAX);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = BASE_ADDR + ADDR_W'(OFF_CONTROL);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [PC_W-1:0]   poll_cnt;
  logic [PC_W-1:0]   poll_cnt_nxt;
  tpg_cfg_t          cfg_q;
  tpg_cfg_t          cfg_nxt;

  logic              wr_start_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;
  logic              wr_accepted;
  logic              wr_done;
  axi_resp_t         wr_resp;

  logic              unused_rdata;
  assign unused_rdata = ^{m_axi_rdata[DATA_W-1:AP_IDLE_BIT+1], m_axi_rdata[AP_IDLE_BIT-1:0]};

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  axil_wr_channel #(
    .ADDR_W (ADDR_W)
  ) u_wr (
    .clk      (aclk),
    .rst      (areset),
    .start    (wr_start_c),
    .addr     (wr_addr_c),
    .data     (wr_data_c),
    .awaddr   (m_axi_awaddr),
    .awvalid  (m_axi_awvalid),
    .awready  (m_axi_awready),
    .wdata    (m_axi_wdata),
    .wstrb    (m_axi_wstrb),
    .wvalid   (m_axi_wvalid),
    .wready   (m_axi_wready),
    .bresp    (m_axi_bresp),
    .bvalid   (m_axi_bvalid),
    .bready   (m_axi_bready),
    .accepted (wr_accepted),
    .done     (wr_done),
    .resp     (wr_resp)
  );

  // Next state; writes are launched in the same cycle the FSM decides on them.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    poll_cnt_nxt = poll_cnt;
    cfg_nxt      = cfg_q;
    wr_start_c   = 1'b0;
    wr_addr_c    = CTRL_ADDR;
    wr_data_c    = CTRL_STOP;
    case (state)
      IDLE, RUN, ERR: begin
        if (cfg_start) begin
          cfg_nxt      = '{height: cfg_height, width: cfg_width,
                           pattern: cfg_pattern, format: cfg_format};
          idx_nxt      = '0;
          poll_cnt_nxt = '0;
          wr_start_c   = 1'b1;
          if (state == RUN) begin
            state_nxt = STOP_WR;
          end else begin
            state_nxt = CFG_WR;
            wr_addr_c = BASE_ADDR + ADDR_W'(cfg_offset(idx_nxt));
            wr_data_c = cfg_data(idx_nxt, cfg_nxt);
          end
        end
      end
      STOP_WR: if (wr_accepted) state_nxt = STOP_B;
      STOP_B: begin
        if (wr_done) state_nxt = (wr_resp == OKAY) ? POLL_AR : ERR;
      end
      POLL_AR: if (m_axi_arvalid && m_axi_arready) state_nxt = POLL_R;
      POLL_R: begin
        if (m_axi_rvalid && m_axi_rready) begin
          if (axi_resp_t'(m_axi_rresp) != OKAY) begin
            state_nxt = ERR;
          end else if (m_axi_rdata[AP_IDLE_BIT]) begin
            state_nxt  = CFG_WR;
            idx_nxt    = '0;
            wr_start_c = 1'b1;
            wr_addr_c  = BASE_ADDR + ADDR_W'(cfg_offset(idx_nxt));
            wr_data_c  = cfg_data(idx_nxt, cfg_q);
          end else begin
            poll_cnt_nxt = poll_cnt + PC_W'(1);
            state_nxt    = (poll_cnt_nxt == POLL_LIMIT) ? ERR : POLL_AR;
          end
        end
      end
      CFG_WR: if (wr_accepted) state_nxt = CFG_B;
      CFG_B: begin
        if (wr_done) begin
          if (wr_resp != OKAY) begin
            state_nxt = ERR;
          end else if (idx == LAST_IDX) begin
            state_nxt = RUN;
          end else begin
            state_nxt  = CFG_WR;
            idx_nxt    = idx + IDX_W'(1);
            wr_start_c = 1'b1;
            wr_addr_c  = BASE_ADDR + ADDR_W'(cfg_offset(idx_nxt));
            wr_data_c  = cfg_data(idx_nxt, cfg_q);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and status/read-channel outputs registered from the next state.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      idx           <= '0;
      poll_cnt      <= '0;
      cfg_q         <= '0;
      busy          <= 1'b0;
      running       <= 1'b0;
      error         <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      poll_cnt      <= poll_cnt_nxt;
      cfg_q         <= cfg_nxt;
      busy          <= state_nxt inside {STOP_WR, STOP_B, POLL_AR, POLL_R, CFG_WR, CFG_B};
      running       <= (state_nxt == RUN);
      error         <= (state_nxt == ERR);
      m_axi_arvalid <= (state_nxt == POLL_AR);
      m_axi_rready  <= (state_nxt == POLL_R);
      if (state_nxt == POLL_AR) m_axi_araddr <= CTRL_ADDR;
    end
  end

endmodule

// File: tb/tb_tpg_cfg_sequencer.sv
// Bench for tpg_cfg_sequencer: AXI4-Lite slave with a small TPG ap_idle model,
// a table of configuration vectors plus stop/poll, error and reset sequences.
module tb_tpg_cfg_sequencer;

  localparam int unsigned POLL_MAX = 8;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_height = '0;
  logic [15:0] cfg_width = '0;
  logic [7:0]  cfg_pattern = '0;
  logic [7:0]  cfg_format = '0;
  logic        busy, running, error;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #10 aclk = ~aclk;

  tpg_cfg_sequencer #(.ADDR_W(12), .BASE_ADDR(12'h000), .POLL_MAX(POLL_MAX)) dut (
    .aclk(aclk), .areset(areset), .cfg_start(cfg_start),
    .cfg_height(cfg_height), .cfg_width(cfg_width),
    .cfg_pattern(cfg_pattern), .cfg_format(cfg_format),
    .busy(busy), .running(running), .error(error),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  // Slave knobs, set by the test.
  logic        always_rdy = 1'b1;
  int          aw_lat = 0;
  int          w_lat = 0;
  int          idle_busy = 0;
  logic        err_en = 1'b0;
  logic [11:0] err_addr = '0;
  logic        stall_en = 1'b0;
  logic [11:0] stall_addr = '0;

  // Slave state and observation log.
  int          aw_cnt = 0, w_cnt = 0;
  logic        aw_have = 1'b0, w_have = 1'b0;
  logic [11:0] aw_q = '0;
  logic [31:0] w_q = '0;
  logic [11:0] log_addr [0:127];
  logic [31:0] log_data [0:127];
  int          log_n = 0, rd_n = 0, dup_n = 0, ovl_n = 0, poll_idx = 0;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      aw_have <= 1'b0; w_have <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
    end else begin
      if (awvalid && awready) begin
        if (aw_have) dup_n <= dup_n + 1;
        aw_have <= 1'b1; aw_q <= awaddr; aw_cnt <= 0; awready <= always_rdy;
      end else if (awvalid && !aw_have) begin
        if (always_rdy || aw_cnt >= aw_lat) awready <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end else awready <= always_rdy;

      if (wvalid && wready) begin
        if (w_have) dup_n <= dup_n + 1;
        w_have <= 1'b1; w_q <= wdata; w_cnt <= 0; wready <= always_rdy;
      end else if (wvalid && !w_have) begin
        if (always_rdy || w_cnt >= w_lat) wready <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end else wready <= always_rdy;

      if (bvalid && bready) bvalid <= 1'b0;
      if (aw_have && w_have && !bvalid && !(stall_en && aw_q == stall_addr)) begin
        bvalid <= 1'b1;
        bresp  <= (err_en && aw_q == err_addr) ? 2'b10 : 2'b00;
        if (log_n < 128) begin
          log_addr[log_n] <= aw_q;
          log_data[log_n] <= w_q;
        end
        log_n   <= log_n + 1;
        aw_have <= 1'b0;
        w_have  <= 1'b0;
        if (aw_q == 12'h000) poll_idx <= 0;
      end

      if (arvalid && arready) begin
        arready  <= 1'b0;
        rvalid   <= 1'b1;
        rresp    <= 2'b00;
        rdata    <= (poll_idx >= idle_busy) ? 32'h0000_0004 : 32'h0000_0001;
        poll_idx <= poll_idx + 1;
        rd_n     <= rd_n + 1;
      end else if (arvalid && !rvalid) arready <= 1'b1;
      if (rvalid && rready) rvalid <= 1'b0;

      if ((awvalid || wvalid || bready) && (arvalid || rready)) ovl_n <= ovl_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pulse_cfg(input logic [15:0] h, input logic [15:0] w,
                           input logic [7:0] p, input logic [7:0] f);
    @(negedge aclk);
    cfg_height = h; cfg_width = w; cfg_pattern = p; cfg_format = f; cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    cfg_height = 16'hDEAD; cfg_width = 16'hBEEF; cfg_pattern = 8'h5A; cfg_format = 8'hA5;
  endtask

  task automatic wait_not_busy(input int max, output logic to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      @(negedge aclk);
      if (!busy) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_error(input int max, output logic to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      @(negedge aclk);
      if (error) begin to = 1'b0; break; end
    end
  endtask

  typedef struct {
    logic [15:0]       h;
    logic [15:0]       w;
    logic [7:0]        pat;
    logic [7:0]        fmt;
    logic              rdy;
    int                awl;
    int                wl;
    int                idle;
    logic              stop;
    int                n_rd;
    logic [4:0][31:0]  exp_data;
  } vec_t;

  vec_t        vt [4];
  logic [11:0] exp_addr [5];
  logic        to;
  int          bw, br;

  initial begin
    exp_addr[0] = 12'h010; exp_addr[1] = 12'h018; exp_addr[2] = 12'h020;
    exp_addr[3] = 12'h040; exp_addr[4] = 12'h000;
    vt[0] = '{16'd640, 16'd480, 8'd9, 8'h02, 1'b1, 0, 0, 0, 1'b0, 0,
              {32'h81, 32'h2, 32'h9, 32'h1E0, 32'h280}};
    vt[1] = '{16'd720, 16'd1280, 8'd3, 8'h03, 1'b0, 5, 0, 3, 1'b1, 4,
              {32'h81, 32'h3, 32'h3, 32'h500, 32'h2D0}};
    vt[2] = '{16'd1080, 16'd1920, 8'h13, 8'h02, 1'b0, 0, 5, 0, 1'b1, 1,
              {32'h81, 32'h2, 32'h13, 32'h780, 32'h438}};
    vt[3] = '{16'hFFFF, 16'h0001, 8'hFF, 8'h03, 1'b0, 2, 3, 1, 1'b1, 2,
              {32'h81, 32'h3, 32'hFF, 32'h1, 32'hFFFF}};

    // Reset state
    repeat (2) @(negedge aclk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 0);
    chk("rst_addr_data", 32'(awaddr) | wdata | 32'(araddr), 0);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    chk("idle_busy", 32'(busy), 0);

    for (int v = 0; v < 4; v++) begin
      always_rdy = vt[v].rdy; aw_lat = vt[v].awl; w_lat = vt[v].wl; idle_busy = vt[v].idle;
      bw = log_n; br = rd_n;
      pulse_cfg(vt[v].h, vt[v].w, vt[v].pat, vt[v].fmt);
      chk($sformatf("v%0d_busy_rise", v), 32'(busy), 1);
      chk($sformatf("v%0d_awvalid_rise", v), 32'({awvalid, wvalid}), 3);
      chk($sformatf("v%0d_first_awaddr", v), 32'(awaddr), vt[v].stop ? 32'h0 : 32'h10);
      chk($sformatf("v%0d_wstrb", v), 32'(wstrb), 32'hF);
      repeat (3) @(negedge aclk);
      cfg_height = 16'h1111; cfg_start = 1'b1;
      @(negedge aclk);
      cfg_start = 1'b0;
      wait_not_busy(600, to);
      chk($sformatf("v%0d_timeout", v), 32'(to), 0);
      repeat (5) @(negedge aclk);
      chk($sformatf("v%0d_status", v), 32'({busy, running, error}), 32'b010);
      chk($sformatf("v%0d_n_writes", v), 32'(log_n - bw), vt[v].stop ? 32'd6 : 32'd5);
      chk($sformatf("v%0d_n_reads", v), 32'(rd_n - br), 32'(vt[v].n_rd));
      if (vt[v].stop) begin
        chk($sformatf("v%0d_stop_addr", v), 32'(log_addr[bw]), 0);
        chk($sformatf("v%0d_stop_data", v), log_data[bw], 0);
        bw = bw + 1;
      end
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("v%0d_addr%0d", v, k), 32'(log_addr[bw+k]), 32'(exp_addr[k]));
        chk($sformatf("v%0d_data%0d", v, k), log_data[bw+k], vt[v].exp_data[k]);
      end
      chk($sformatf("v%0d_dup_ovl", v), 32'(dup_n + ovl_n), 0);
    end
    chk("prot", 32'({awprot, arprot}), 0);

    // ap_idle never returns: exactly POLL_MAX reads, then error
    always_rdy = 1'b1; idle_busy = 100; bw = log_n; br = rd_n;
    pulse_cfg(16'd640, 16'd480, 8'd9, 8'h02);
    chk("to_running_drop", 32'(running), 0);
    wait_error(600, to);
    chk("to_timeout", 32'(to), 0);
    repeat (5) @(negedge aclk);
    chk("to_reads", 32'(rd_n - br), 32'(POLL_MAX));
    chk("to_writes", 32'(log_n - bw), 1);
    chk("to_status", 32'({busy, running, error}), 32'b001);

    // SLVERR on BG_ID write
    idle_busy = 0; err_en = 1'b1; err_addr = 12'h020; bw = log_n;
    pulse_cfg(16'd100, 16'd200, 8'd7, 8'h02);
    chk("se_err_clear", 32'({busy, error}), 32'b10);
    chk("se_first_awaddr", 32'(awaddr), 32'h10);
    wait_error(600, to);
    chk("se_timeout", 32'(to), 0);
    repeat (20) @(negedge aclk);
    chk("se_writes", 32'(log_n - bw), 3);
    chk("se_last_addr", 32'(log_addr[bw+2]), 32'h20);
    chk("se_status", 32'({busy, running, error}), 32'b001);
    chk("se_no_aw", 32'(awvalid), 0);
    err_en = 1'b0; bw = log_n;
    pulse_cfg(16'd100, 16'd200, 8'd7, 8'h02);
    chk("se2_err_clear", 32'({busy, error}), 32'b10);
    chk("se2_first_awaddr", 32'(awaddr), 32'h10);
    wait_not_busy(600, to);
    chk("se2_timeout", 32'(to), 0);
    chk("se2_running", 32'(running), 1);
    chk("se2_writes", 32'(log_n - bw), 5);
    chk("se2_h_data", log_data[bw], 32'd100);
    chk("se2_ctrl_data", log_data[bw+4], 32'h81);

    // Asynchronous reset while waiting for the BG_ID response
    stall_en = 1'b1; stall_addr = 12'h020;
    pulse_cfg(16'd300, 16'd400, 8'd1, 8'h03);
    to = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge aclk);
      if (bready && awaddr == 12'h020) begin to = 1'b0; break; end
    end
    chk("ar_reach_b2", 32'(to), 0);
    #3 areset = 1'b1;
    #1;
    chk("ar_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 0);
    chk("ar_status", 32'({busy, running, error}), 0);
    chk("ar_addr_data", 32'(awaddr) | wdata | 32'(wstrb), 0);
    @(negedge aclk);
    stall_en = 1'b0; areset = 1'b0;
    bw = log_n;
    pulse_cfg(16'd300, 16'd400, 8'd1, 8'h03);
    chk("ar_restart_awaddr", 32'(awaddr), 32'h10);
    wait_not_busy(600, to);
    chk("ar_timeout", 32'(to), 0);
    chk("ar_writes", 32'(log_n - bw), 5);
    chk("ar_fmt_data", log_data[bw+3], 32'h3);
    chk("ar_running", 32'(running), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
